// File: rtl/sprite_motion_pkg.sv
// sprite_motion_pkg: shared state encoding, keycodes and rectangle overlap helper
// for the sprite motion controller.
package sprite_motion_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISE     = 2'd1,
        FALL     = 2'd2
    } mstate_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_JUMP  = 8'h1A;

    // Strict AABB test: touching edges do not overlap.
    function automatic logic aabb_overlap(
        input int ax, input int ay, input int aw, input int ah,
        input int bx, input int by, input int bw, input int bh
    );
        return ax < bx + bw && bx < ax + aw && ay < by + bh && by < ay + ah;
    endfunction

endpackage

// File: rtl/sprite_collide.sv
// sprite_collide: checks the candidate sprite rectangle against every platform and
// reports side block, support, nearest landing top and lowest head-bump underside.
module sprite_collide
    import sprite_motion_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int NUM_PLAT = 4,
    parameter int SPR_SIZE = 16
) (
    input  logic signed [COORD_W+1:0]        hx_i,
    input  logic signed [COORD_W+1:0]        vx_i,
    input  logic signed [COORD_W+1:0]        y_i,
    input  logic signed [COORD_W+1:0]        ny_i,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_x_i,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_y_i,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_w_i,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_h_i,
    output logic                             h_block_o,
    output logic                             support_o,
    output logic                             land_hit_o,
    output logic signed [COORD_W+1:0]        land_y_o,
    output logic                             head_hit_o,
    output logic signed [COORD_W+1:0]        head_y_o
);

    typedef logic signed [COORD_W+1:0] s_t;
    localparam s_t S = s_t'(SPR_SIZE);

    s_t   bx, by, bw, bh, bt;
    logic xo;

    always_comb begin
        h_block_o  = 1'b0;
        support_o  = 1'b0;
        land_hit_o = 1'b0;
        land_y_o   = '0;
        head_hit_o = 1'b0;
        head_y_o   = '0;
        bx = '0;
        by = '0;
        bw = '0;
        bh = '0;
        bt = '0;
        xo = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            bx = s_t'(plat_x_i[i*COORD_W +: COORD_W]);
            by = s_t'(plat_y_i[i*COORD_W +: COORD_W]);
            bw = s_t'(plat_w_i[i*COORD_W +: COORD_W]);
            bh = s_t'(plat_h_i[i*COORD_W +: COORD_W]);
            bt = by + bh;
            xo = bw != '0 && vx_i < bx + bw && bx < vx_i + S;
            if (bw != '0 && aabb_overlap(int'(hx_i), int'(y_i), SPR_SIZE, SPR_SIZE,
                                         int'(bx), int'(by), int'(bw), int'(bh)))
                h_block_o = 1'b1;
            if (xo && y_i + S == by)
                support_o = 1'b1;
            // Several tops crossed in one frame: the highest one wins.
            if (xo && y_i + S <= by && ny_i + S > by && (!land_hit_o || by < land_y_o)) begin
                land_hit_o = 1'b1;
                land_y_o   = by;
            end
            if (xo && y_i >= bt && ny_i < bt && (!head_hit_o || bt > head_y_o)) begin
                head_hit_o = 1'b1;
                head_y_o   = bt;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-frame walk/jump/gravity integrator for the player sprite with
// screen-bound and platform collision resolution.
module sprite_motion_ctrl
    import sprite_motion_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int VEL_W      = 6,
    parameter int NUM_PLAT   = 4,
    parameter int SPR_SIZE   = 16,
    parameter int SCREEN_W   = 640,
    parameter int FLOOR_Y    = 416,
    parameter int SPAWN_X    = 0,
    parameter int SPAWN_Y    = 100,
    parameter int WALK_SPEED = 2,
    parameter int JUMP_VEL   = 9,
    parameter int GRAV_DIV   = 6,
    parameter int MAX_FALL   = 4
) (
    input  logic                          frame_clk,
    input  logic                          Reset,
    input  logic        [7:0]             keycode,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_x,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_y,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_w,
    input  logic        [NUM_PLAT*COORD_W-1:0] plat_h,
    output logic        [COORD_W-1:0]     pos_x,
    output logic        [COORD_W-1:0]     pos_y,
    output logic        [COORD_W-1:0]     size,
    output logic signed [VEL_W-1:0]       vel_y,
    output logic        [1:0]             mstate,
    output logic                          facing_left
);

    localparam int W2 = COORD_W + 2;
    localparam int GW = GRAV_DIV > 1 ? $clog2(GRAV_DIV) : 1;
    typedef logic signed [W2-1:0] s_t;
    localparam s_t S     = s_t'(SPR_SIZE);
    localparam s_t X_MAX = s_t'(SCREEN_W - SPR_SIZE);
    localparam s_t Y_MAX = s_t'(FLOOR_Y - SPR_SIZE);
    localparam s_t WS    = s_t'(WALK_SPEED);
    localparam logic signed [VEL_W-1:0] V_JUMP = VEL_W'(-JUMP_VEL);
    localparam logic signed [VEL_W-1:0] V_MAX  = VEL_W'(MAX_FALL);

    logic        [COORD_W-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
    logic signed [VEL_W-1:0]   vel_q, vel_d, vel_inc;
    mstate_t                   st_q, st_d;
    logic                      face_q;
    logic        [GW-1:0]      gcnt_q;
    s_t   px, py, vy, dx, nx_raw, nx, rx, ny;
    s_t   land_y, head_y, land_top, land_pos, head_pos, y_n;
    logic h_block, support, land_hit, head_hit, floor_hit, do_land, do_head, wrap, grounded_ok;

    always_comb begin
        px     = s_t'(pos_x_q);
        py     = s_t'(pos_y_q);
        vy     = s_t'(vel_q);
        dx     = keycode == KEY_LEFT ? -WS : keycode == KEY_RIGHT ? WS : '0;
        nx_raw = px + dx;
        nx     = nx_raw[W2-1] ? '0 : nx_raw > X_MAX ? X_MAX : nx_raw;
        ny     = py + vy;
    end

    assign pos_x_d = h_block ? pos_x_q : nx[COORD_W-1:0];
    assign rx      = s_t'(pos_x_d);

    sprite_collide #(
        .COORD_W  (COORD_W),
        .NUM_PLAT (NUM_PLAT),
        .SPR_SIZE (SPR_SIZE)
    ) u_collide (
        .hx_i       (nx),
        .vx_i       (rx),
        .y_i        (py),
        .ny_i       (ny),
        .plat_x_i   (plat_x),
        .plat_y_i   (plat_y),
        .plat_w_i   (plat_w),
        .plat_h_i   (plat_h),
        .h_block_o  (h_block),
        .support_o  (support),
        .land_hit_o (land_hit),
        .land_y_o   (land_y),
        .head_hit_o (head_hit),
        .head_y_o   (head_y)
    );

    // Airborne resolution: the nearest surface along the direction of travel wins.
    always_comb begin
        land_top    = land_y - S;
        land_pos    = land_hit && land_top < Y_MAX ? land_top : Y_MAX;
        head_pos    = head_hit ? head_y : '0;
        floor_hit   = ny > Y_MAX;
        do_land     = !vy[W2-1] && vy != '0 && (land_hit || floor_hit);
        do_head     = vy[W2-1] && (head_hit || ny[W2-1]);
        y_n         = do_land ? land_pos : do_head ? head_pos : ny;
        pos_y_d     = y_n[W2-1] ? '0 : y_n > Y_MAX ? Y_MAX[COORD_W-1:0] : y_n[COORD_W-1:0];
        wrap        = gcnt_q == GW'(GRAV_DIV - 1);
        vel_inc     = wrap && vel_q < V_MAX ? vel_q + VEL_W'(1) : vel_q;
        vel_d       = do_land || do_head ? '0 : vel_inc;
        st_d        = do_land ? GROUNDED : do_head ? FALL : vel_d[VEL_W-1] ? RISE : FALL;
        grounded_ok = py == Y_MAX || support;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            pos_x_q <= COORD_W'(SPAWN_X);
            pos_y_q <= COORD_W'(SPAWN_Y);
            vel_q   <= '0;
            st_q    <= FALL;
            face_q  <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            pos_x_q <= pos_x_d;
            if (dx != '0)
                face_q <= dx[W2-1];
            case (st_q)
                GROUNDED: begin
                    if (keycode == KEY_JUMP) begin
                        vel_q  <= V_JUMP;
                        gcnt_q <= '0;
                        st_q   <= RISE;
                    end else if (!grounded_ok) begin
                        vel_q <= '0;
                        st_q  <= FALL;
                    end
                end
                default: begin
                    pos_y_q <= pos_y_d;
                    vel_q   <= vel_d;
                    st_q    <= st_d;
                    gcnt_q  <= wrap ? '0 : gcnt_q + GW'(1);
                end
            endcase
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign size        = COORD_W'(SPR_SIZE);
    assign vel_y       = vel_q;
    assign mstate      = st_q;
    assign facing_left = face_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: scenario and randomized checks of sprite_motion_ctrl against a
// frame-level behavioural model of the motion rules.
module tb_sprite_motion_ctrl;

    localparam int CW = 10;
    localparam int NP = 4;

    logic              frame_clk = 1'b0;
    logic              Reset = 1'b0;
    logic [7:0]        keycode = 8'h00;
    logic [NP*CW-1:0]  plat_x = '0, plat_y = '0, plat_w = '0, plat_h = '0;
    logic [CW-1:0]     pos_x, pos_y, size;
    logic [5:0]        vel_y;
    logic [1:0]        mstate;
    logic              facing_left;

    int total = 0;
    int bad = 0;
    int mx, my, mv, ms, mg, mf;
    int px[NP], py[NP], pw[NP], ph[NP];

    always #5 frame_clk = ~frame_clk;

    sprite_motion_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .plat_x      (plat_x),
        .plat_y      (plat_y),
        .plat_w      (plat_w),
        .plat_h      (plat_h),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .size        (size),
        .vel_y       (vel_y),
        .mstate      (mstate),
        .facing_left (facing_left)
    );

    task automatic set_plat(input int i, input int x, input int y, input int w, input int h);
        px[i] = x; py[i] = y; pw[i] = w; ph[i] = h;
        plat_x[i*CW +: CW] = CW'(x);
        plat_y[i*CW +: CW] = CW'(y);
        plat_w[i*CW +: CW] = CW'(w);
        plat_h[i*CW +: CW] = CW'(h);
    endtask

    task automatic clear_plats();
        for (int i = 0; i < NP; i++)
            set_plat(i, $urandom_range(0, 600), $urandom_range(0, 400), 0, $urandom_range(1, 50));
    endtask

    function automatic logic xov(input int x, input int i);
        return pw[i] != 0 && x < px[i] + pw[i] && px[i] < x + 16;
    endfunction

    function automatic logic hits(input int x, input int y, input int i);
        return xov(x, i) && y < py[i] + ph[i] && py[i] < y + 16;
    endfunction

    task automatic model_reset();
        mx = 0; my = 100; mv = 0; ms = 2; mg = 0; mf = 0;
    endtask

    // One frame of the motion rules: walk with wall/side checks, then jump/gravity/landing.
    task automatic model_step(input logic [7:0] k);
        int dx, nx, ny, best;
        logic blk, sup, hit;
        dx = (k == 8'h04) ? -2 : (k == 8'h07) ? 2 : 0;
        nx = mx + dx;
        if (nx < 0) nx = 0;
        if (nx > 624) nx = 624;
        blk = 1'b0;
        for (int i = 0; i < NP; i++) if (hits(nx, my, i)) blk = 1'b1;
        if (!blk) mx = nx;
        if (dx != 0) mf = (dx < 0) ? 1 : 0;
        if (ms == 0) begin
            sup = (my == 400);
            for (int i = 0; i < NP; i++) if (xov(mx, i) && my + 16 == py[i]) sup = 1'b1;
            if (k == 8'h1A) begin mv = -9; mg = 0; ms = 1; end
            else if (!sup) begin mv = 0; ms = 2; end
        end else begin
            ny = my + mv;
            hit = 1'b0;
            if (mv > 0) begin
                best = 100000;
                for (int i = 0; i < NP; i++)
                    if (xov(mx, i) && my + 16 <= py[i] && ny + 16 > py[i] && py[i] - 16 < best) best = py[i] - 16;
                if (ny > 400 && best > 400) best = 400;
                if (best != 100000) begin my = best; ms = 0; hit = 1'b1; end
            end else if (mv < 0) begin
                best = -1;
                for (int i = 0; i < NP; i++)
                    if (xov(mx, i) && my >= py[i] + ph[i] && ny < py[i] + ph[i] && py[i] + ph[i] > best) best = py[i] + ph[i];
                if (ny < 0 && best < 0) best = 0;
                if (best >= 0) begin my = best; ms = 2; hit = 1'b1; end
            end
            if (hit) mv = 0;
            else begin
                my = ny;
                if (mg == 5 && mv < 4) mv = mv + 1;
                ms = (mv < 0) ? 1 : 2;
            end
            mg = (mg + 1) % 6;
        end
    endtask

    task automatic step(input logic [7:0] k);
        keycode = k;
        @(posedge frame_clk);
        model_step(k);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [28:0] dut_v();
        return {pos_x, pos_y, vel_y, mstate, facing_left};
    endfunction

    function automatic logic [28:0] mod_v();
        return {CW'(mx), CW'(my), 6'(mv), 2'(ms), 1'(mf)};
    endfunction

    task automatic test_reset();
        #1 Reset = 1'b1;
        #1;
        total++;
        if (dut_v() !== {10'd0, 10'd100, 6'd0, 2'd2, 1'b0}) begin
            bad++; $display("FAIL reset_state got=%h want=%h", dut_v(), {10'd0, 10'd100, 6'd0, 2'd2, 1'b0});
        end
        total++;
        if (size !== 10'd16) begin bad++; $display("FAIL size got=%0d want=16", size); end
        @(posedge frame_clk); #1;
        total++;
        if (dut_v() !== {10'd0, 10'd100, 6'd0, 2'd2, 1'b0}) begin
            bad++; $display("FAIL reset_hold got=%h", dut_v());
        end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_fall();
        int n = 0, maxy = 0, maxv = -100, v;
        while (mstate !== 2'd0 && n < 400) begin
            step(8'h00); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL fall f%0d got=%h want=%h", n, dut_v(), mod_v()); end
            if (int'(pos_y) > maxy) maxy = int'(pos_y);
            v = int'($signed(vel_y));
            if (v > maxv) maxv = v;
        end
        total++;
        if (pos_y !== 10'd400 || mstate !== 2'd0 || vel_y !== 6'd0) begin
            bad++; $display("FAIL fall_land got y=%0d st=%0d v=%0d want y=400 st=0 v=0", pos_y, mstate, vel_y);
        end
        total++;
        if (maxy > 400 || maxv != 4) begin bad++; $display("FAIL fall_limits got maxy=%0d maxv=%0d want <=400 and 4", maxy, maxv); end
    endtask

    task automatic test_jump();
        int n;
        for (int i = 0; i < 100; i++) begin
            step(8'h07);
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL walk f%0d got=%h want=%h", i, dut_v(), mod_v()); end
        end
        total++;
        if (pos_x !== 10'd200) begin bad++; $display("FAIL walk_x got=%0d want=200", pos_x); end
        step(8'h1A);
        total++;
        if (pos_y !== 10'd400 || vel_y !== 6'h37 || mstate !== 2'd1) begin
            bad++; $display("FAIL jump_launch got y=%0d v=%h st=%0d want 400 37 1", pos_y, vel_y, mstate);
        end
        step(8'h00);
        total++;
        if (pos_y !== 10'd391) begin bad++; $display("FAIL jump_first got=%0d want=391", pos_y); end
        n = 1;
        while (vel_y !== 6'd0 && n < 200) begin
            step(8'h1A); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL jump_air f%0d got=%h want=%h", n, dut_v(), mod_v()); end
        end
        total++;
        if (n != 54) begin bad++; $display("FAIL jump_apex got=%0d frames want=54", n); end
        total++;
        if (mstate !== 2'd2 || vel_y !== 6'd0) begin bad++; $display("FAIL no_rejump got st=%0d v=%h want 2 0", mstate, vel_y); end
        n = 0;
        while (mstate !== 2'd0 && n < 300) begin
            step(8'h00); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL jump_fall f%0d got=%h want=%h", n, dut_v(), mod_v()); end
        end
        total++;
        if (pos_y !== 10'd400 || vel_y !== 6'd0) begin bad++; $display("FAIL jump_land got y=%0d v=%h want 400 0", pos_y, vel_y); end
    endtask

    task automatic test_platform();
        int n = 0;
        clear_plats();
        set_plat(0, 96, 368, 64, 16);
        do_reset();
        for (int i = 0; i < 50; i++) begin
            step(8'h07);
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL plat_walk f%0d got=%h want=%h", i, dut_v(), mod_v()); end
        end
        while (mstate !== 2'd0 && n < 300) begin
            step(8'h00); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL plat_fall f%0d got=%h want=%h", n, dut_v(), mod_v()); end
        end
        total++;
        if (pos_x !== 10'd100 || pos_y !== 10'd352 || mstate !== 2'd0) begin
            bad++; $display("FAIL plat_land got x=%0d y=%0d st=%0d want 100 352 0", pos_x, pos_y, mstate);
        end
        n = 0;
        while (pos_x < 10'd160 && n < 100) begin
            step(8'h07); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL plat_edge f%0d got=%h want=%h", n, dut_v(), mod_v()); end
        end
        total++;
        if (pos_x !== 10'd160 || mstate !== 2'd2 || pos_y !== 10'd352) begin
            bad++; $display("FAIL plat_walkoff got x=%0d y=%0d st=%0d want 160 352 2", pos_x, pos_y, mstate);
        end
        n = 0;
        while (mstate !== 2'd0 && n < 300) begin
            step(8'h00); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL plat_drop f%0d got=%h want=%h", n, dut_v(), mod_v()); end
        end
        total++;
        if (pos_y !== 10'd400) begin bad++; $display("FAIL plat_drop_land got=%0d want=400", pos_y); end
    endtask

    task automatic test_head_bump();
        int n = 0;
        for (int i = 0; i < 30; i++) begin
            step(8'h04);
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL bump_walk f%0d got=%h want=%h", i, dut_v(), mod_v()); end
        end
        total++;
        if (pos_x !== 10'd100 || facing_left !== 1'b1) begin bad++; $display("FAIL bump_pos got x=%0d f=%0d want 100 1", pos_x, facing_left); end
        step(8'h1A);
        step(8'h00);
        step(8'h00);
        total++;
        if (pos_y !== 10'd384 || vel_y !== 6'd0 || mstate !== 2'd2) begin
            bad++; $display("FAIL head_bump got y=%0d v=%h st=%0d want 384 0 2", pos_y, vel_y, mstate);
        end
        while (mstate !== 2'd0 && n < 300) begin
            step(8'h00); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL bump_fall f%0d got=%h want=%h", n, dut_v(), mod_v()); end
        end
        total++;
        if (pos_y !== 10'd400) begin bad++; $display("FAIL bump_land got=%0d want=400", pos_y); end
    endtask

    task automatic test_walls();
        clear_plats();
        for (int i = 0; i < 300; i++) step(8'h07);
        total++;
        if (pos_x !== 10'd624 || facing_left !== 1'b0 || dut_v() !== mod_v()) begin
            bad++; $display("FAIL wall_right got x=%0d f=%0d want 624 0", pos_x, facing_left);
        end
        for (int i = 0; i < 320; i++) step(8'h04);
        total++;
        if (pos_x !== 10'd0 || facing_left !== 1'b1 || dut_v() !== mod_v()) begin
            bad++; $display("FAIL wall_left got x=%0d f=%0d want 0 1", pos_x, facing_left);
        end
        set_plat(0, 96, 390, 64, 40);
        for (int i = 0; i < 60; i++) step(8'h07);
        total++;
        if (pos_x !== 10'd80 || facing_left !== 1'b0 || dut_v() !== mod_v()) begin
            bad++; $display("FAIL side_block got x=%0d f=%0d want 80 0", pos_x, facing_left);
        end
    endtask

    task automatic test_reset_mid_rise();
        clear_plats();
        step(8'h1A);
        for (int i = 0; i < 3; i++) step(8'h00);
        total++;
        if (mstate !== 2'd1) begin bad++; $display("FAIL pre_reset_rise got st=%0d want 1", mstate); end
        Reset = 1'b1;
        #2;
        total++;
        if (dut_v() !== {10'd0, 10'd100, 6'd0, 2'd2, 1'b0}) begin
            bad++; $display("FAIL reset_mid_rise got=%h want=%h", dut_v(), {10'd0, 10'd100, 6'd0, 2'd2, 1'b0});
        end
        #1 Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_disabled();
        int n = 0;
        for (int i = 0; i < NP; i++) set_plat(i, i * 8, 200 + i * 40, 0, 30);
        while (mstate !== 2'd0 && n < 400) begin
            step(8'h00); n++;
            total++;
            if (dut_v() !== mod_v()) begin bad++; $display("FAIL disabled f%0d got=%h want=%h", n, dut_v(), mod_v()); end
        end
        total++;
        if (pos_y !== 10'd400 || mstate !== 2'd0) begin bad++; $display("FAIL disabled_land got y=%0d st=%0d want 400 0", pos_y, mstate); end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] k;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < NP; i++)
                set_plat(i, $urandom_range(0, 600), $urandom_range(120, 420),
                         ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 96), $urandom_range(4, 48));
            do_reset();
            for (int f = 0; f < 400; f++) begin
                r = $urandom_range(0, 9);
                k = r < 3 ? 8'h07 : r < 6 ? 8'h04 : r == 6 ? 8'h1A : r == 7 ? 8'h00 : 8'($urandom);
                step(k);
                total++;
                if (dut_v() !== mod_v()) begin bad++; $display("FAIL random s%0d f%0d key=%h got=%h want=%h", s, f, k, dut_v(), mod_v()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fall();
        test_jump();
        test_platform();
        test_head_bump();
        test_walls();
        test_reset_mid_rise();
        test_disabled();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
